// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
//
// Prioritised interrupt controller that feeds the special-register block's
// irq_in. Each external source is synchronised, latched into a pending
// register, and filtered by a mask. When the core has interrupts enabled, the
// lowest-numbered eligible source wins. The controller then raises a one-cycle
// request and holds the winner's ID in CAUSE until software writes
// end-of-interrupt (EOI) to the CAUSE index.
//
// Parameters
//   N          number of interrupt sources (1..16)
//   EDGE_MASK  per-source trigger mode, 1 = rising edge, 0 = level
//   SR_BASE    special-register index of MASK; PEND = +1, CAUSE/EOI = +2
//
// Ports
//   clk       core clock, all state changes on its rising edge
//   rst       synchronous active-low reset
//   irq_src   asynchronous interrupt lines, active high
//   irq_en    interrupt enable from the special-register block
//   sr_ie     special-register write strobe
//   sr_sel    special-register index (read and write)
//   sr_in     special-register write data
//   irq_out   one-cycle interrupt request
//   irq_busy  high while an interrupt is being serviced
//   sr_rdata  read data for MASK/PEND/CAUSE, zero for any other index
// -----------------------------------------------------------------------------
module irq_ctrl #(
  parameter int          N         = 8,
  parameter logic [15:0] EDGE_MASK = 16'h00FF,
  parameter logic [15:0] SR_BASE   = 16'd4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  irq_src,
  input  logic          irq_en,
  input  logic          sr_ie,
  input  logic [15:0]   sr_sel,
  input  logic [15:0]   sr_in,
  output logic          irq_out,
  output logic          irq_busy,
  output logic [15:0]   sr_rdata
);

  localparam logic [15:0] MASK_IDX  = SR_BASE;
  localparam logic [15:0] PEND_IDX  = SR_BASE + 16'd1;
  localparam logic [15:0] CAUSE_IDX = SR_BASE + 16'd2;

  localparam logic [N-1:0] EDGE_N = EDGE_MASK[N-1:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] sync1_q, sync1_d;
  logic [N-1:0] sync2_q, sync2_d;
  logic [N-1:0] sync3_q, sync3_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] mask_q, mask_d;
  logic [15:0]  cause_q, cause_d;
  logic         irq_out_q, irq_out_d;
  logic         irq_busy_q, irq_busy_d;

  logic         mask_wr;
  logic         pend_wr;
  logic         eoi_wr;
  logic [N-1:0] pend_set;
  logic [N-1:0] pend_clr;
  logic [N-1:0] eligible;
  logic [N-1:0] win_oh;
  logic [3:0]   win_id;
  logic [15:0]  mask_ext;
  logic [15:0]  pend_ext;

  // Register-bus decode. The casts take the low N bits of the write data;
  // the upper bits of MASK and PEND do not exist for N < 16.
  always_comb begin
    mask_wr = sr_ie && (sr_sel == MASK_IDX);
    pend_wr = sr_ie && (sr_sel == PEND_IDX);
    eoi_wr  = sr_ie && (sr_sel == CAUSE_IDX);
  end

  // Three-stage chain per source: two stages tame metastability, the third
  // holds the previous synchronised value so a rising edge can be seen.
  // Edge sources set pend on a 0->1 of the synchronised line. Level sources
  // set it on every cycle the synchronised line is high.
  always_comb begin
    sync1_d  = irq_src;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    pend_set = (sync2_q & ~sync3_q & EDGE_N) | (sync2_q & ~EDGE_N);
  end

  // Fixed priority: scan from the top down so the lowest set index is the
  // last assignment and therefore wins. win_oh is kept as a one-hot vector so
  // the edge-mode clear needs no variable-width indexing.
  always_comb begin
    eligible = pend_q & mask_q;
    win_id   = 4'd0;
    win_oh   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_id    = 4'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  // Next-state logic for the request FSM and the software-visible registers.
  // A MASK or PEND write in IDLE defers the request by a cycle so software
  // never races its own register update. Only edge winners have their pend
  // bit consumed on dispatch; a level source keeps requesting while its line
  // stays high. Pend clears are applied before sets, so a set always beats a
  // clear in the same cycle.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cause_d  = cause_q;
    pend_clr = '0;

    if (mask_wr) begin
      mask_d = N'(sr_in);
    end
    if (pend_wr) begin
      pend_clr = N'(sr_in);
    end

    case (state_q)
      IDLE: begin
        if (irq_en && (|eligible) && !mask_wr && !pend_wr) begin
          state_d  = REQ;
          cause_d  = {1'b1, 11'b0, win_id};
          pend_clr = pend_clr | (win_oh & EDGE_N);
        end
      end
      REQ: begin
        state_d = SERVICE;
      end
      SERVICE: begin
        if (eoi_wr) begin
          state_d     = IDLE;
          cause_d[15] = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pend_d     = (pend_q & ~pend_clr) | pend_set;
    irq_out_d  = (state_d == REQ);
    irq_busy_d = (state_d == SERVICE);
  end

  // All state lives here. Reset is synchronous and active low, so pending
  // interrupts and any in-flight service are abandoned on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync3_q    <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
      cause_q    <= '0;
      irq_out_q  <= 1'b0;
      irq_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      cause_q    <= cause_d;
      irq_out_q  <= irq_out_d;
      irq_busy_q <= irq_busy_d;
    end
  end

  // Read mux. It is combinational from sr_sel and returns zero for foreign
  // indices, so the top level can OR it with the other register blocks.
  always_comb begin
    mask_ext          = '0;
    mask_ext[N-1:0]   = mask_q;
    pend_ext          = '0;
    pend_ext[N-1:0]   = pend_q;
    sr_rdata          = '0;
    if (sr_sel == MASK_IDX) begin
      sr_rdata = mask_ext;
    end else if (sr_sel == PEND_IDX) begin
      sr_rdata = pend_ext;
    end else if (sr_sel == CAUSE_IDX) begin
      sr_rdata = cause_q;
    end
  end

  assign irq_out  = irq_out_q;
  assign irq_busy = irq_busy_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl
//
// Directed bench for irq_ctrl. Two instances share clock, reset and the
// register bus. dut uses all-edge sources. dut_l uses EDGE_MASK = 8'hFE, which
// makes source 0 level-triggered. Each instance has its own irq_src.
// Expected values are hand-computed from the controller's documented timing.
// A source that rises just after edge E0 sets pend after E3 and requests
// after E4.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

  localparam logic [15:0] MASK_IDX  = 16'd4;
  localparam logic [15:0] PEND_IDX  = 16'd5;
  localparam logic [15:0] CAUSE_IDX = 16'd6;

  logic        clk;
  logic        rst;
  logic [7:0]  irq_src;
  logic [7:0]  irq_src_l;
  logic        irq_en;
  logic        sr_ie;
  logic [15:0] sr_sel;
  logic [15:0] sr_in;
  logic        irq_out, irq_out_l;
  logic        irq_busy, irq_busy_l;
  logic [15:0] sr_rdata, sr_rdata_l;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl #(.N(8), .EDGE_MASK(16'h00FF), .SR_BASE(16'd4)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .irq_en(irq_en),
    .sr_ie(sr_ie), .sr_sel(sr_sel), .sr_in(sr_in),
    .irq_out(irq_out), .irq_busy(irq_busy), .sr_rdata(sr_rdata)
  );

  irq_ctrl #(.N(8), .EDGE_MASK(16'h00FE), .SR_BASE(16'd4)) dut_l (
    .clk(clk), .rst(rst), .irq_src(irq_src_l), .irq_en(irq_en),
    .sr_ie(sr_ie), .sr_sel(sr_sel), .sr_in(sr_in),
    .irq_out(irq_out_l), .irq_busy(irq_busy_l), .sr_rdata(sr_rdata_l)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung simulation
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and settle 1 ns past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Register read through the combinational read port of either instance
  task automatic readCheck(input string tag, input logic [15:0] sel,
                           input logic [15:0] exp, input bit lvl);
    sr_sel = sel;
    #1;
    checkOutput(tag, lvl ? sr_rdata_l : sr_rdata, exp);
  endtask

  // One register write, committed on the next rising edge
  task automatic applyStimulus(input logic [15:0] sel, input logic [15:0] data);
    sr_ie  = 1'b1;
    sr_sel = sel;
    sr_in  = data;
    step();
    sr_ie  = 1'b0;
    sr_in  = 16'h0000;
  endtask

  initial begin
    rst       = 1'b0;
    irq_src   = 8'hFF;
    irq_src_l = 8'h00;
    irq_en    = 1'b0;
    sr_ie     = 1'b0;
    sr_sel    = 16'h0000;
    sr_in     = 16'h0000;

    // ---- reset sweep ----
    step();
    step();
    checkBit("rst_irq_out", irq_out, 1'b0);
    checkBit("rst_irq_busy", irq_busy, 1'b0);
    readCheck("rst_mask", MASK_IDX, 16'h0000, 1'b0);
    readCheck("rst_pend", PEND_IDX, 16'h0000, 1'b0);
    readCheck("rst_cause", CAUSE_IDX, 16'h0000, 1'b0);
    readCheck("rst_other_idx", 16'd3, 16'h0000, 1'b0);

    rst = 1'b1;
    step();
    step();
    readCheck("sync_lat_2clk", PEND_IDX, 16'h0000, 1'b0);
    step();
    readCheck("sync_lat_3clk", PEND_IDX, 16'h00FF, 1'b0);
    step();
    checkBit("masked_no_irq", irq_out, 1'b0);
    irq_src = 8'h00;
    applyStimulus(PEND_IDX, 16'hFFFF);
    readCheck("pend_w1c_all", PEND_IDX, 16'h0000, 1'b0);

    // ---- priority ----
    applyStimulus(MASK_IDX, 16'hFFFF);
    readCheck("mask_upper_ignored", MASK_IDX, 16'h00FF, 1'b0);
    irq_en  = 1'b1;
    irq_src = 8'h24;
    step();
    irq_src = 8'h00;
    step();
    step();
    checkBit("prio_wait_out", irq_out, 1'b0);
    readCheck("prio_pend_both", PEND_IDX, 16'h0024, 1'b0);
    step();
    checkBit("prio_irq_out", irq_out, 1'b1);
    checkBit("prio_busy_in_req", irq_busy, 1'b0);
    readCheck("prio_cause", CAUSE_IDX, 16'h8002, 1'b0);
    readCheck("prio_pend_left", PEND_IDX, 16'h0020, 1'b0);
    irq_en = 1'b0;
    step();
    checkBit("prio_single_pulse", irq_out, 1'b0);
    checkBit("prio_busy", irq_busy, 1'b1);
    irq_en = 1'b1;
    step();
    checkBit("service_blocks_out", irq_out, 1'b0);
    irq_en = 1'b0;
    applyStimulus(CAUSE_IDX, 16'h0000);
    checkBit("eoi_busy_low", irq_busy, 1'b0);
    readCheck("eoi_cause_bit15", CAUSE_IDX, 16'h0002, 1'b0);
    step();
    checkBit("en_low_no_out", irq_out, 1'b0);
    irq_en = 1'b1;
    step();
    checkBit("prio_second_out", irq_out, 1'b1);
    readCheck("prio_second_cause", CAUSE_IDX, 16'h8005, 1'b0);
    readCheck("prio_pend_empty", PEND_IDX, 16'h0000, 1'b0);
    step();
    irq_en = 1'b0;
    applyStimulus(CAUSE_IDX, 16'hABCD);
    readCheck("eoi2_cause", CAUSE_IDX, 16'h0005, 1'b0);

    // ---- masking and enable gating ----
    applyStimulus(MASK_IDX, 16'h0001);
    irq_src = 8'h09;
    step();
    irq_src = 8'h00;
    step();
    step();
    step();
    checkBit("en_gate_no_out", irq_out, 1'b0);
    readCheck("mask_pend", PEND_IDX, 16'h0009, 1'b0);
    irq_en = 1'b1;
    step();
    checkBit("en_gate_out", irq_out, 1'b1);
    readCheck("en_gate_cause", CAUSE_IDX, 16'h8000, 1'b0);
    readCheck("masked_src_kept", PEND_IDX, 16'h0008, 1'b0);
    step();
    checkBit("svc_busy_enter", irq_busy, 1'b1);

    // ---- service blocking ----
    applyStimulus(MASK_IDX, 16'h0003);
    irq_src = 8'h02;
    step();
    irq_src = 8'h00;
    step();
    step();
    readCheck("svc_pend_set", PEND_IDX, 16'h000A, 1'b0);
    checkBit("svc_no_out", irq_out, 1'b0);
    step();
    checkBit("svc_no_out2", irq_out, 1'b0);
    checkBit("svc_busy_hold", irq_busy, 1'b1);
    applyStimulus(CAUSE_IDX, 16'h1234);
    checkBit("svc_eoi_busy", irq_busy, 1'b0);
    checkBit("svc_eoi_out", irq_out, 1'b0);
    readCheck("svc_eoi_cause", CAUSE_IDX, 16'h0000, 1'b0);
    step();
    checkBit("svc_next_out", irq_out, 1'b1);
    readCheck("svc_next_cause", CAUSE_IDX, 16'h8001, 1'b0);
    readCheck("svc_next_pend", PEND_IDX, 16'h0008, 1'b0);
    step();
    irq_en = 1'b0;
    applyStimulus(CAUSE_IDX, 16'h0000);
    checkBit("svc_eoi2_busy", irq_busy, 1'b0);

    // A register write in IDLE defers the request by one cycle
    applyStimulus(MASK_IDX, 16'h000F);
    irq_en = 1'b1;
    applyStimulus(PEND_IDX, 16'h0000);
    checkBit("wr_blocks_req", irq_out, 1'b0);
    step();
    checkBit("wr_deferred_req", irq_out, 1'b1);
    readCheck("wr_deferred_cause", CAUSE_IDX, 16'h8003, 1'b0);

    // EOI while in REQ is ignored
    applyStimulus(CAUSE_IDX, 16'h0000);
    checkBit("eoi_in_req_busy", irq_busy, 1'b1);
    readCheck("eoi_in_req_cause", CAUSE_IDX, 16'h8003, 1'b0);
    step();
    checkBit("eoi_in_req_still", irq_busy, 1'b1);
    applyStimulus(CAUSE_IDX, 16'h0000);
    checkBit("eoi_after_req", irq_busy, 1'b0);
    readCheck("eoi_after_cause", CAUSE_IDX, 16'h0003, 1'b0);

    // ---- mid-service reset ----
    applyStimulus(MASK_IDX, 16'h0010);
    irq_src = 8'h10;
    step();
    irq_src = 8'h00;
    step();
    step();
    step();
    checkBit("msr_out", irq_out, 1'b1);
    readCheck("msr_cause", CAUSE_IDX, 16'h8004, 1'b0);
    step();
    checkBit("msr_busy", irq_busy, 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    checkBit("msr_busy_clr", irq_busy, 1'b0);
    checkBit("msr_out_clr", irq_out, 1'b0);
    readCheck("msr_cause_clr", CAUSE_IDX, 16'h0000, 1'b0);
    readCheck("msr_mask_clr", MASK_IDX, 16'h0000, 1'b0);
    applyStimulus(CAUSE_IDX, 16'hFFFF);
    checkBit("msr_eoi_ignored", irq_busy, 1'b0);
    readCheck("msr_eoi_cause", CAUSE_IDX, 16'h0000, 1'b0);
    step();
    checkBit("msr_no_req", irq_out, 1'b0);

    // ---- level vs edge (dut_l, source 0 level) ----
    applyStimulus(MASK_IDX, 16'h0001);
    irq_src_l = 8'h01;
    step();
    step();
    step();
    readCheck("lvl_pend", PEND_IDX, 16'h0001, 1'b1);
    checkBit("lvl_wait_out", irq_out_l, 1'b0);
    step();
    checkBit("lvl_out", irq_out_l, 1'b1);
    readCheck("lvl_cause", CAUSE_IDX, 16'h8000, 1'b1);
    readCheck("lvl_pend_kept", PEND_IDX, 16'h0001, 1'b1);
    step();
    checkBit("lvl_busy", irq_busy_l, 1'b1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(CAUSE_IDX, 16'h0000);
      checkBit("lvl_eoi_busy", irq_busy_l, 1'b0);
      step();
      checkBit("lvl_rereq", irq_out_l, 1'b1);
      step();
      checkBit("lvl_rebusy", irq_busy_l, 1'b1);
    end
    applyStimulus(PEND_IDX, 16'h0001);
    readCheck("lvl_set_wins", PEND_IDX, 16'h0001, 1'b1);
    irq_src_l = 8'h00;
    step();
    step();
    step();
    applyStimulus(PEND_IDX, 16'h0001);
    readCheck("lvl_w1c_low", PEND_IDX, 16'h0000, 1'b1);
    applyStimulus(CAUSE_IDX, 16'h0000);
    step();
    checkBit("lvl_done_out", irq_out_l, 1'b0);
    checkBit("lvl_done_busy", irq_busy_l, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
